fpga_rst_ctrl: RTL and testbench
================================

Name: fpga_rst_ctrl

Overview:
- Reset sequencer for the FPGA Cortex-M3 subsystem.
- Takes the board-level power-on reset and the run-time reset requests: core SYSRESETREQ, watchdog, and lockup.
- Produces two staged, registered active-low resets: por_rst_n for the debug/power-on domain and sys_rst_n for the system domain.
- Each output feeds a per-domain reset synchroniser. The block also records a sticky reset-cause register for software.

Parameters:
- HOLD_CYCLES, 16: cycles a reset output is held low after its trigger is removed. Legal range 1..2^CNT_W-1.
- STAGGER_CYCLES, 4: cycles between por_rst_n release and sys_rst_n release at power-on. Legal range 1..2^CNT_W-1.
- CNT_W, 8: width of the shared down-counter.

Ports:
- clk, input, 1: sole clock. All other inputs are synchronous to clk.
- rst_in, input, 1: asynchronous, active-high reset (power-on/board reset).
- sysresetreq, input, 1: core system reset request, level.
- wdog_rst_req, input, 1: watchdog reset request, level.
- lockup, input, 1: core lockup indication, level.
- lockup_rst_en, input, 1: when 1, lockup generates a warm reset.
- cause_clr, input, 1: single-cycle pulse that clears rst_cause.
- por_rst_n, output, 1: power-on domain reset, active-low, registered.
- sys_rst_n, output, 1: system domain reset, active-low, registered.
- rst_busy, output, 1: high while any reset sequence is in progress.
- rst_cause, output, 4: sticky cause bits. bit0 = POR, bit1 = SYSRESETREQ, bit2 = watchdog, bit3 = lockup.

Behaviour:
- Derived signal: warm_req = sysresetreq | wdog_rst_req | (lockup & lockup_rst_en).
- FSM states: POR_HOLD, POR_STAG, RUN, WARM_HOLD. CNT_W-bit down-counter cnt.
- While rst_in=1 (asynchronous):
  - state = POR_HOLD, cnt = HOLD_CYCLES-1.
  - por_rst_n = 0, sys_rst_n = 0, rst_busy = 1, rst_cause = 4'b0001.
- POR_HOLD:
  - Both outputs low. cnt decrements each edge.
  - On an edge with cnt==0: go to POR_STAG, load cnt = STAGGER_CYCLES-1, por_rst_n <= 1.
  - Result: por_rst_n rises on the HOLD_CYCLES-th rising edge after rst_in falls. Edge 1 is the first edge with rst_in low.
  - warm_req is ignored in this state.
- POR_STAG:
  - por_rst_n = 1, sys_rst_n = 0. cnt decrements.
  - On an edge with cnt==0: go to RUN, sys_rst_n <= 1, rst_busy <= 0.
  - sys_rst_n therefore rises at edge HOLD_CYCLES+STAGGER_CYCLES.
  - warm_req is ignored in this state.
- RUN:
  - Both outputs high.
  - warm_req sampled 1 at edge N: go to WARM_HOLD, sys_rst_n <= 0 and rst_busy <= 1 (visible after edge N), load cnt = HOLD_CYCLES-1.
  - por_rst_n never falls in a warm reset.
- WARM_HOLD:
  - sys_rst_n = 0.
  - If warm_req=1: cnt reloads HOLD_CYCLES-1.
  - Otherwise, if cnt!=0: cnt decrements.
  - If cnt==0 and warm_req=0: go to RUN, sys_rst_n <= 1, rst_busy <= 0.
  - A single-cycle request at edge N gives sys_rst_n low for exactly HOLD_CYCLES cycles, rising at edge N+HOLD_CYCLES.
  - A held request keeps sys_rst_n low until HOLD_CYCLES edges after the last edge on which warm_req was sampled 1.
- rst_cause update rules:
  - On the RUN->WARM_HOLD edge: OR in the bits of the active requests (bit1 sysresetreq, bit2 wdog_rst_req, bit3 lockup&lockup_rst_en).
  - In WARM_HOLD: also OR in any newly active request.
  - bit0 is set only by rst_in.
  - cause_clr=1 clears all bits. If cause_clr and a set occur on the same edge, set wins for the bits being set; all other bits clear.
- Outputs are driven directly from flops, with no combinational path from inputs. The next stage synchronises deassertion.
- rst_in asserted in any state forces the reset values immediately. The sequence restarts from POR_HOLD when it is released.
- Illegal/unused state encodings recover to POR_HOLD with outputs low.

Test Plan:
- Power-on, defaults (16/4): release rst_in -> por_rst_n rises at edge 16, sys_rst_n at edge 20, rst_busy falls at edge 20, rst_cause=4'b0001.
- sysresetreq pulsed 1 cycle at edge N in RUN -> sys_rst_n low after N, high after N+16; por_rst_n stays 1; rst_cause=4'b0011.
- wdog_rst_req held 10 cycles (edges N..N+9) -> sys_rst_n high after edge N+25. Pulse cause_clr with no request -> rst_cause=0000.
- lockup=1 with lockup_rst_en=0 -> no reset, rst_cause unchanged. Set lockup_rst_en=1 -> warm reset with bit3 set.
- Requests asserted during POR_HOLD/POR_STAG -> ignored, power-on timing unchanged. Assert rst_in mid-WARM_HOLD -> both outputs low immediately, rst_cause=0001, full power-on sequence on release.
- cause_clr coincident with wdog_rst_req entering WARM_HOLD with rst_cause=0011 -> rst_cause=0100. Re-run power-on with HOLD_CYCLES=1, STAGGER_CYCLES=1 -> por_rst_n at edge 1, sys_rst_n at edge 2.

Source files
------------

// File: rtl/fpga_rst_ctrl.sv
// Reset sequencer for the Cortex-M3 subsystem: staged power-on release of
// por_rst_n then sys_rst_n, warm resets on sys_rst_n only, and a sticky cause register.
module fpga_rst_ctrl #(
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 4,
    parameter int CNT_W          = 8
) (
    input  logic       clk,
    input  logic       rst_in,
    input  logic       sysresetreq,
    input  logic       wdog_rst_req,
    input  logic       lockup,
    input  logic       lockup_rst_en,
    input  logic       cause_clr,
    output logic       por_rst_n,
    output logic       sys_rst_n,
    output logic       rst_busy,
    output logic [3:0] rst_cause
);

    typedef enum logic [1:0] {
        POR_HOLD  = 2'd0,
        POR_STAG  = 2'd1,
        RUN       = 2'd2,
        WARM_HOLD = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAG_LD = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             por_q, por_d;
    logic             sys_q, sys_d;
    logic             busy_q, busy_d;
    logic [3:0]       cause_q, cause_d;

    logic       warm_req;
    logic [3:0] req_bits;
    logic [3:0] cause_set;

    assign req_bits  = {lockup & lockup_rst_en, wdog_rst_req, sysresetreq, 1'b0};
    assign warm_req  = |req_bits;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        por_d     = por_q;
        sys_d     = sys_q;
        busy_d    = busy_q;
        cause_set = '0;

        unique case (state_q)
            POR_HOLD: begin
                por_d  = 1'b0;
                sys_d  = 1'b0;
                busy_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d = POR_STAG;
                    cnt_d   = STAG_LD;
                    por_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            POR_STAG: begin
                por_d  = 1'b1;
                sys_d  = 1'b0;
                busy_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d = RUN;
                    sys_d   = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            RUN: begin
                if (warm_req) begin
                    state_d   = WARM_HOLD;
                    cnt_d     = HOLD_LD;
                    sys_d     = 1'b0;
                    busy_d    = 1'b1;
                    cause_set = req_bits;
                end
            end
            WARM_HOLD: begin
                cause_set = req_bits;
                // Any live request restarts the full hold window.
                if (warm_req) begin
                    cnt_d = HOLD_LD;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    state_d = RUN;
                    sys_d   = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = POR_HOLD;
                cnt_d   = HOLD_LD;
                por_d   = 1'b0;
                sys_d   = 1'b0;
                busy_d  = 1'b1;
            end
        endcase

        cause_d = (cause_clr ? 4'b0000 : cause_q) | cause_set;
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state_q <= POR_HOLD;
            cnt_q   <= HOLD_LD;
            por_q   <= 1'b0;
            sys_q   <= 1'b0;
            busy_q  <= 1'b1;
            cause_q <= 4'b0001;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            por_q   <= por_d;
            sys_q   <= sys_d;
            busy_q  <= busy_d;
            cause_q <= cause_d;
        end
    end

    assign por_rst_n = por_q;
    assign sys_rst_n = sys_q;
    assign rst_busy  = busy_q;
    assign rst_cause = cause_q;

endmodule

// File: tb/tb_fpga_rst_ctrl.sv
// Bench for fpga_rst_ctrl: edge-count/deadline model checked every cycle,
// plus directed literal checks of the power-on and warm-reset timing.
module tb_fpga_rst_ctrl;

    localparam int H = 16;
    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst_in = 1'b1;
    logic       sysresetreq = 1'b0;
    logic       wdog_rst_req = 1'b0;
    logic       lockup = 1'b0;
    logic       lockup_rst_en = 1'b0;
    logic       cause_clr = 1'b0;
    logic       por_rst_n, sys_rst_n, rst_busy;
    logic [3:0] rst_cause;
    logic       por2, sys2, busy2;
    logic [3:0] cause2;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    fpga_rst_ctrl #(.HOLD_CYCLES(H), .STAGGER_CYCLES(S), .CNT_W(8)) dut (
        .clk(clk), .rst_in(rst_in), .sysresetreq(sysresetreq),
        .wdog_rst_req(wdog_rst_req), .lockup(lockup), .lockup_rst_en(lockup_rst_en),
        .cause_clr(cause_clr), .por_rst_n(por_rst_n), .sys_rst_n(sys_rst_n),
        .rst_busy(rst_busy), .rst_cause(rst_cause)
    );

    fpga_rst_ctrl #(.HOLD_CYCLES(1), .STAGGER_CYCLES(1), .CNT_W(8)) dut_min (
        .clk(clk), .rst_in(rst_in), .sysresetreq(sysresetreq),
        .wdog_rst_req(wdog_rst_req), .lockup(lockup), .lockup_rst_en(lockup_rst_en),
        .cause_clr(cause_clr), .por_rst_n(por2), .sys_rst_n(sys2),
        .rst_busy(busy2), .rst_cause(cause2)
    );

    always #5 clk = ~clk;

    // Model: m_e counts edges since rst_in release; a warm reset ends at edge m_end.
    int         m_e = 0;
    bit         m_warm = 1'b0;
    int         m_end = 0;
    logic [3:0] m_cause = 4'b0001;
    logic [3:0] m_bits;
    bit         m_up;

    always @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            m_e     = 0;
            m_warm  = 1'b0;
            m_cause = 4'b0001;
        end else begin
            m_bits  = {lockup & lockup_rst_en, wdog_rst_req, sysresetreq, 1'b0};
            m_up    = (m_e >= H + S);
            m_cause = (cause_clr ? 4'b0000 : m_cause) | (m_up ? m_bits : 4'b0000);
            m_e     = m_e + 1;
            if (m_up) begin
                if (m_bits != 4'b0000) begin
                    m_warm = 1'b1;
                    m_end  = m_e + H;
                end else if (m_warm && m_e >= m_end) begin
                    m_warm = 1'b0;
                end
            end
        end
    end

    function automatic logic m_por();
        return logic'(m_e >= H);
    endfunction

    function automatic logic m_sys();
        return logic'((m_e >= H + S) && !m_warm);
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_por",   {3'b0, por_rst_n}, {3'b0, m_por()});
            chk("cyc_sys",   {3'b0, sys_rst_n}, {3'b0, m_sys()});
            chk("cyc_busy",  {3'b0, rst_busy},  {3'b0, ~m_sys()});
            chk("cyc_cause", rst_cause, m_cause);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #3;
        end
    endtask

    initial begin
        tick(3);
        chk("rst_por",   {3'b0, por_rst_n}, 4'd0);
        chk("rst_sys",   {3'b0, sys_rst_n}, 4'd0);
        chk("rst_busy",  {3'b0, rst_busy},  4'd1);
        chk("rst_cause", rst_cause, 4'b0001);
        chk_en = 1'b1;

        // Power-on release: por at edge 16, sys at edge 20.
        rst_in = 1'b0;
        tick(15);
        chk("pon_por_e15", {3'b0, por_rst_n}, 4'd0);
        chk("model_por_e15", {3'b0, m_por()}, 4'd0);
        tick(1);
        chk("pon_por_e16", {3'b0, por_rst_n}, 4'd1);
        chk("pon_sys_e16", {3'b0, sys_rst_n}, 4'd0);
        chk("model_por_e16", {3'b0, m_por()}, 4'd1);
        tick(3);
        chk("pon_sys_e19", {3'b0, sys_rst_n}, 4'd0);
        tick(1);
        chk("pon_sys_e20", {3'b0, sys_rst_n}, 4'd1);
        chk("pon_busy_e20", {3'b0, rst_busy}, 4'd0);
        chk("pon_cause", rst_cause, 4'b0001);
        chk("model_sys_e20", {3'b0, m_sys()}, 4'd1);
        tick(2);

        // Single-cycle SYSRESETREQ.
        sysresetreq = 1'b1;
        tick(1);
        sysresetreq = 1'b0;
        chk("sreq_sys_n", {3'b0, sys_rst_n}, 4'd0);
        chk("sreq_por_n", {3'b0, por_rst_n}, 4'd1);
        chk("sreq_busy_n", {3'b0, rst_busy}, 4'd1);
        tick(15);
        chk("sreq_sys_n15", {3'b0, sys_rst_n}, 4'd0);
        tick(1);
        chk("sreq_sys_n16", {3'b0, sys_rst_n}, 4'd1);
        chk("sreq_cause", rst_cause, 4'b0011);
        chk("model_sreq_cause", m_cause, 4'b0011);
        tick(2);

        // Watchdog held for 10 edges: release at N+25.
        wdog_rst_req = 1'b1;
        tick(10);
        wdog_rst_req = 1'b0;
        tick(15);
        chk("wdog_sys_n24", {3'b0, sys_rst_n}, 4'd0);
        tick(1);
        chk("wdog_sys_n25", {3'b0, sys_rst_n}, 4'd1);
        chk("wdog_cause", rst_cause, 4'b0111);
        cause_clr = 1'b1;
        tick(1);
        cause_clr = 1'b0;
        chk("clr_cause", rst_cause, 4'b0000);

        // Lockup gated by lockup_rst_en.
        lockup = 1'b1;
        tick(5);
        chk("lk_dis_sys", {3'b0, sys_rst_n}, 4'd1);
        chk("lk_dis_cause", rst_cause, 4'b0000);
        lockup_rst_en = 1'b1;
        tick(1);
        lockup = 1'b0;
        lockup_rst_en = 1'b0;
        chk("lk_en_sys", {3'b0, sys_rst_n}, 4'd0);
        chk("lk_en_cause", rst_cause, 4'b1000);
        tick(16);
        chk("lk_rel_sys", {3'b0, sys_rst_n}, 4'd1);

        // Requests during power-on are ignored.
        rst_in = 1'b1;
        #1;
        chk("por2_por", {3'b0, por_rst_n}, 4'd0);
        chk("por2_cause", rst_cause, 4'b0001);
        tick(1);
        rst_in = 1'b0;
        sysresetreq = 1'b1;
        wdog_rst_req = 1'b1;
        tick(15);
        chk("por2_por_e15", {3'b0, por_rst_n}, 4'd0);
        tick(1);
        chk("por2_por_e16", {3'b0, por_rst_n}, 4'd1);
        tick(3);
        chk("por2_sys_e19", {3'b0, sys_rst_n}, 4'd0);
        sysresetreq = 1'b0;
        wdog_rst_req = 1'b0;
        tick(1);
        chk("por2_sys_e20", {3'b0, sys_rst_n}, 4'd1);
        chk("por2_cause_e20", rst_cause, 4'b0001);
        tick(2);

        // rst_in in the middle of a warm reset.
        sysresetreq = 1'b1;
        tick(1);
        sysresetreq = 1'b0;
        tick(5);
        rst_in = 1'b1;
        #1;
        chk("mid_por", {3'b0, por_rst_n}, 4'd0);
        chk("mid_sys", {3'b0, sys_rst_n}, 4'd0);
        chk("mid_busy", {3'b0, rst_busy}, 4'd1);
        chk("mid_cause", rst_cause, 4'b0001);
        tick(1);
        rst_in = 1'b0;
        tick(20);
        chk("mid_rel_sys", {3'b0, sys_rst_n}, 4'd1);

        // cause_clr coincident with a new watchdog request.
        sysresetreq = 1'b1;
        tick(1);
        sysresetreq = 1'b0;
        tick(16);
        chk("co_pre_cause", rst_cause, 4'b0011);
        wdog_rst_req = 1'b1;
        cause_clr = 1'b1;
        tick(1);
        wdog_rst_req = 1'b0;
        cause_clr = 1'b0;
        chk("co_cause", rst_cause, 4'b0100);
        tick(16);
        chk("co_rel_sys", {3'b0, sys_rst_n}, 4'd1);

        // Minimum-length instance: por at edge 1, sys at edge 2.
        rst_in = 1'b1;
        tick(1);
        chk("min_rst_por", {3'b0, por2}, 4'd0);
        chk("min_rst_sys", {3'b0, sys2}, 4'd0);
        rst_in = 1'b0;
        tick(1);
        chk("min_por_e1", {3'b0, por2}, 4'd1);
        chk("min_sys_e1", {3'b0, sys2}, 4'd0);
        chk("min_busy_e1", {3'b0, busy2}, 4'd1);
        tick(1);
        chk("min_sys_e2", {3'b0, sys2}, 4'd1);
        chk("min_busy_e2", {3'b0, busy2}, 4'd0);
        tick(25);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
